// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StCheck,
    StCommit
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator, one data bit per enabled cycle, MSB-first register.
module cfg_crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    fb    = crc[15] ^ din;
    crc_d = crc;
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc <= CRC16_INIT;
    end else begin
      crc <= crc_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams config words LSB-first into a fabric shift chain and pulses set when loaded.
// Optional CRC-16 trailer check is enabled by defining CFG_LOADER_CRC_EN.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              chain_cen,
  output logic              chain_din,
  output logic              chain_set,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              din_d, done_d;

`ifdef CFG_LOADER_CRC_EN
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
  logic [15:0] exp_q, exp_d;
  logic [15:0] crc_val;
  logic        err_d;

  cfg_crc16_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StIdle && start),
    .en  (chain_cen),
    .din (chain_din),
    .crc (crc_val)
  );
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    din_d   = 1'b0;
    done_d  = 1'b0;
`ifdef CFG_LOADER_CRC_EN
    exp_d   = exp_q;
    err_d   = err;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
`ifdef CFG_LOADER_CRC_EN
          err_d   = 1'b0;
`endif
        end
      end
      StFetch: begin
        if (cfg_valid && cfg_ready) begin
`ifdef CFG_LOADER_CRC_EN
          // A fetch after the chain is full carries the expected CRC.
          if (cnt_q == FULL_CNT) begin
            state_d = StCheck;
            exp_d   = cfg_data[15:0];
          end else
`endif
          begin
            state_d = StShift;
            word_d  = cfg_data;
            idx_d   = '0;
            din_d   = cfg_data[0];
          end
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef CFG_LOADER_CRC_EN
          state_d = StFetch;
`else
          state_d = StCommit;
`endif
        end else if (idx_q == LAST_IDX) begin
          state_d = StFetch;
        end else begin
          idx_d   = idx_q + 1'b1;
          din_d   = word_q[idx_d];
        end
      end
      StCheck: begin
`ifdef CFG_LOADER_CRC_EN
        if (exp_q == crc_val) begin
          state_d = StCommit;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StCommit: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a pending commit or CRC verdict.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      din_d   = 1'b0;
      done_d  = 1'b0;
`ifdef CFG_LOADER_CRC_EN
      err_d   = err;
`endif
    end
  end

  // Outputs are registered decodes of the next state, so each reflects the current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      word_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cfg_ready <= 1'b0;
      chain_cen <= 1'b0;
      chain_din <= 1'b0;
      chain_set <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cfg_ready <= (state_d == StFetch);
      chain_cen <= (state_d == StShift);
      chain_din <= din_d;
      chain_set <= (state_d == StCommit);
      busy      <= (state_d != StIdle);
      done      <= done_d;
    end
  end

`ifdef CFG_LOADER_CRC_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= '0;
      err   <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err   <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
